// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: movement, growth and collision control for the snake.
// Holds the head and body segment list, steps the snake one cell per move
// tick in the latched direction, grows on add_cube, detects wall and self
// collisions, and answers registered per-cell "is body" queries.
//
// Optional build macro: WRAP_EN -- walls wrap around instead of killing;
// hit_wall is then constant 0.
//
// Ports:
//   CLK_50M, RST                  clock, async active-high reset
//   key_up/down/left/right        level direction requests
//   restart                       pulse, DIE -> START
//   add_cube                      pulse, grow by one segment
//   pix_x, pix_y                  query cell
//   head_x, head_y                head cell
//   body_len                      segment count including head
//   game_state                    0=START 1=RUN 2=DIE
//   hit_wall, hit_body            one-cycle death pulses
//   is_body                       query result, 1-cycle latency
module snake_body_ctrl #(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned X_MAX    = 38,
  parameter int unsigned Y_MAX    = 28
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       restart,
  input  logic       add_cube,
  input  logic [5:0] pix_x,
  input  logic [4:0] pix_y,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic [4:0] body_len,
  output logic [1:0] game_state,
  output logic       hit_wall,
  output logic       hit_body,
  output logic       is_body
);

  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned XW     = 6;
  localparam int unsigned YW     = 5;
  localparam int          INIT_X = 10;
  localparam int          INIT_Y = 15;

  typedef enum logic [1:0] {ST_START = 2'd0, ST_RUN = 2'd1, ST_DIE = 2'd2} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  function automatic dir_t f_reverse(input dir_t d);
    case (d)
      DIR_UP:   f_reverse = DIR_DOWN;
      DIR_DOWN: f_reverse = DIR_UP;
      DIR_LEFT: f_reverse = DIR_RIGHT;
      default:  f_reverse = DIR_LEFT;
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  dir_t             r_dir, r_next_dir, w_key_dir, w_eff_dir;
  logic [CNT_W-1:0] r_cnt;
  logic [XW-1:0]    r_seg_x [MAX_LEN];
  logic [YW-1:0]    r_seg_y [MAX_LEN];
  logic [LEN_W-1:0] r_len, w_body_lim;
  logic             r_grow, r_hit_wall, r_hit_body, r_is_body;
  logic             w_key, w_key_ok, w_tick, w_grow, w_wall, w_body;
  logic             w_move, w_restart, w_is_body;
  logic [XW-1:0]    w_nx, w_ny;

  // FSM state register
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) r_state <= ST_START;
    else     r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_START: if (w_key) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_tick && (w_wall || w_body)) w_state_nxt = ST_DIE;
      ST_DIE:   if (restart) w_state_nxt = ST_START;
      default:  w_state_nxt = ST_START;
    endcase
  end

  // Key decode, tick, candidate head and collision detection
  always_comb begin
    w_key     = key_up | key_down | key_left | key_right;
    w_key_dir = DIR_RIGHT;
    if (key_up)        w_key_dir = DIR_UP;
    else if (key_down) w_key_dir = DIR_DOWN;
    else if (key_left) w_key_dir = DIR_LEFT;

    w_tick    = (r_state == ST_RUN) && (r_cnt == CNT_W'(TICK_DIV - 1));
    // In the tick cycle the reverse test is against the direction being applied now
    w_eff_dir = w_tick ? r_next_dir : r_dir;
    w_key_ok  = w_key && (r_state != ST_DIE) && (w_key_dir != f_reverse(w_eff_dir));
    w_grow    = (r_grow | add_cube) && (r_len < LEN_W'(MAX_LEN));
    w_restart = (r_state == ST_DIE) && restart;

    w_nx = r_seg_x[0];
    w_ny = {1'b0, r_seg_y[0]};
    case (r_next_dir)
      DIR_UP:   w_ny = w_ny - XW'(1);
      DIR_DOWN: w_ny = w_ny + XW'(1);
      DIR_LEFT: w_nx = w_nx - XW'(1);
      default:  w_nx = w_nx + XW'(1);
    endcase

    w_wall = 1'b0;
`ifdef WRAP_EN
    if (w_nx == '0)                 w_nx = XW'(X_MAX);
    else if (w_nx == XW'(X_MAX + 1)) w_nx = XW'(1);
    if (w_ny == '0)                 w_ny = XW'(Y_MAX);
    else if (w_ny == XW'(Y_MAX + 1)) w_ny = XW'(1);
`else
    w_wall = (w_nx == '0) || (w_nx > XW'(X_MAX)) || (w_ny == '0) || (w_ny > XW'(Y_MAX));
`endif

    // Tail vacates its cell on a normal move, so it only counts when growing
    w_body_lim = w_grow ? r_len : (r_len - LEN_W'(1));
    w_body     = 1'b0;
    for (int i = 1; i < int'(MAX_LEN); i++) begin
      if ((LEN_W'(i) < w_body_lim) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny[YW-1:0]))
        w_body = 1'b1;
    end
    w_move = w_tick && !w_wall && !w_body;

    w_is_body = 1'b0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((LEN_W'(i) < r_len) && (r_seg_x[i] == pix_x) && (r_seg_y[i] == pix_y))
        w_is_body = 1'b1;
    end
  end

  // Datapath: segments, direction, counter, growth, pulses, query
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        r_seg_x[i] <= (i < int'(INIT_LEN)) ? XW'(INIT_X - i) : '0;
        r_seg_y[i] <= (i < int'(INIT_LEN)) ? YW'(INIT_Y) : '0;
      end
      r_len      <= LEN_W'(INIT_LEN);
      r_dir      <= DIR_RIGHT;
      r_next_dir <= DIR_RIGHT;
      r_cnt      <= '0;
      r_grow     <= 1'b0;
      r_hit_wall <= 1'b0;
      r_hit_body <= 1'b0;
      r_is_body  <= 1'b0;
    end else if (w_restart) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        r_seg_x[i] <= (i < int'(INIT_LEN)) ? XW'(INIT_X - i) : '0;
        r_seg_y[i] <= (i < int'(INIT_LEN)) ? YW'(INIT_Y) : '0;
      end
      r_len      <= LEN_W'(INIT_LEN);
      r_dir      <= DIR_RIGHT;
      r_next_dir <= DIR_RIGHT;
      r_cnt      <= '0;
      r_grow     <= 1'b0;
      r_hit_wall <= 1'b0;
      r_hit_body <= 1'b0;
      r_is_body  <= 1'b0;
    end else begin
      r_hit_wall <= w_tick && w_wall;
      r_hit_body <= w_tick && !w_wall && w_body;
      r_is_body  <= w_is_body;
      if (r_state == ST_RUN) r_cnt <= w_tick ? '0 : (r_cnt + CNT_W'(1));
      if (w_key_ok) r_next_dir <= w_key_dir;
      if (w_tick)   r_dir <= r_next_dir;
      r_grow <= w_move ? 1'b0 : (r_grow | add_cube);
      if (w_move) begin
        for (int i = int'(MAX_LEN) - 1; i > 0; i--) begin
          r_seg_x[i] <= r_seg_x[i-1];
          r_seg_y[i] <= r_seg_y[i-1];
        end
        r_seg_x[0] <= w_nx;
        r_seg_y[0] <= w_ny[YW-1:0];
        if (w_grow) r_len <= r_len + LEN_W'(1);
      end
    end
  end

  assign head_x     = r_seg_x[0];
  assign head_y     = {1'b0, r_seg_y[0]};
  assign body_len   = r_len;
  assign game_state = r_state;
  assign hit_wall   = r_hit_wall;
  assign hit_body   = r_hit_body;
  assign is_body    = r_is_body;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Testbench for snake_body_ctrl: queue-based snake model, per-cycle
// expected-output scoreboard, directed scenarios plus random play.
module tb_snake_body_ctrl;

  localparam int TD   = 10;
  localparam int MAXL = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_up, key_down, key_left, key_right, restart, add_cube;
  logic [5:0] pix_x;
  logic [4:0] pix_y;
  logic [5:0] head_x, head_y;
  logic [4:0] body_len;
  logic [1:0] game_state;
  logic       hit_wall, hit_body, is_body;

  snake_body_ctrl #(.TICK_DIV(TD)) dut (
    .CLK_50M(clk), .RST(rst),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .restart(restart), .add_cube(add_cube), .pix_x(pix_x), .pix_y(pix_y),
    .head_x(head_x), .head_y(head_y), .body_len(body_len), .game_state(game_state),
    .hit_wall(hit_wall), .hit_body(hit_body), .is_body(is_body)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hx, hy, len, st, hw, hb, ib;
  } exp_t;

  exp_t q[$];
  exp_t rq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: body as a list of cells, head first
  int bx[$];
  int by[$];
  int m_state, m_dir, m_ndir, m_cnt;
  int m_grow, m_hw, m_hb, m_ib;

  function automatic int rev(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic void model_reset();
    bx = {10, 9, 8};
    by = {15, 15, 15};
    m_state = 0; m_dir = 3; m_ndir = 3; m_cnt = 0;
    m_grow = 0; m_hw = 0; m_hb = 0; m_ib = 0;
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.hx = bx[0]; e.hy = by[0]; e.len = bx.size(); e.st = m_state;
    e.hw = m_hw; e.hb = m_hb; e.ib = m_ib;
    return e;
  endfunction

  function automatic void model_step(input bit u, input bit d, input bit l, input bit r,
                                     input bit add, input bit rs, input int px, input int py);
    bit tick, key, grow, wall, body;
    int k, md, eff, nx, ny, lim;
    tick = (m_state == 1) && (m_cnt == TD - 1);
    m_ib = 0;
    foreach (bx[i]) if (bx[i] == px && by[i] == py) m_ib = 1;
    m_hw = 0; m_hb = 0;
    key = u | d | l | r;
    k = u ? 0 : d ? 1 : l ? 2 : 3;
    if (m_state == 2) begin
      if (rs) model_reset();
      return;
    end
    md  = m_ndir;
    eff = tick ? m_ndir : m_dir;
    if (key && k != rev(eff)) m_ndir = k;
    if (m_state == 0) begin
      if (key) m_state = 1;
      if (add) m_grow = 1;
      return;
    end
    if (!tick) begin
      m_cnt++;
      if (add) m_grow = 1;
      return;
    end
    m_cnt = 0;
    m_dir = md;
    grow = (m_grow != 0 || add) && (bx.size() < MAXL);
    nx = bx[0] + int'(md == 3) - int'(md == 2);
    ny = by[0] + int'(md == 1) - int'(md == 0);
`ifdef WRAP_EN
    if (nx == 0) nx = 38; else if (nx == 39) nx = 1;
    if (ny == 0) ny = 28; else if (ny == 29) ny = 1;
    wall = 0;
`else
    wall = (nx < 1) || (nx > 38) || (ny < 1) || (ny > 28);
`endif
    lim  = grow ? bx.size() : bx.size() - 1;
    body = 0;
    for (int i = 1; i < lim; i++) if (bx[i] == nx && by[i] == ny) body = 1;
    if (wall) begin
      m_hw = 1; m_state = 2; if (add) m_grow = 1;
    end else if (body) begin
      m_hb = 1; m_state = 2; if (add) m_grow = 1;
    end else begin
      bx.push_front(nx); by.push_front(ny);
      if (!grow) begin
        void'(bx.pop_back()); void'(by.pop_back());
      end
      m_grow = 0;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    n_vec++;
    chk({tag, ".head_x"}, int'(head_x), e.hx);
    chk({tag, ".head_y"}, int'(head_y), e.hy);
    chk({tag, ".body_len"}, int'(body_len), e.len);
    chk({tag, ".game_state"}, int'(game_state), e.st);
    chk({tag, ".hit_wall"}, int'(hit_wall), e.hw);
    chk({tag, ".hit_body"}, int'(hit_body), e.hb);
    chk({tag, ".is_body"}, int'(is_body), e.ib);
  endtask

  task automatic cp(input string nm, input int act, input int expv);
    n_vec++;
    chk(nm, act, expv);
  endtask

  // Scoreboard monitor: one expected vector per clock
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp_all("cyc", e);
      end
    end
  end

  // Async reset monitor: outputs must be at reset values before the next edge
  initial begin
    exp_t e;
    forever begin
      @(posedge rst);
      #1;
      if (rq.size() > 0) begin
        e = rq.pop_front();
        cmp_all("async_rst", e);
      end
    end
  end

  task automatic step(input bit u, input bit d, input bit l, input bit r,
                      input bit add, input bit rs, input bit rst_in);
    int px, py, idx;
    bit rising;
    @(negedge clk);
    if ($urandom_range(1, 0) == 1) begin
      idx = $urandom_range(bx.size() - 1, 0);
      px = bx[idx]; py = by[idx];
    end else begin
      px = $urandom_range(39, 0); py = $urandom_range(29, 0);
    end
    key_up = u; key_down = d; key_left = l; key_right = r;
    add_cube = add; restart = rs;
    pix_x = 6'(px); pix_y = 5'(py);
    if (rst_in) begin
      rising = (rst !== 1'b1);
      model_reset();
      if (rising) rq.push_back(cur_exp());
      rst = 1'b1;
    end else begin
      rst = 1'b0;
      model_step(u, d, l, r, add, rs, px, py);
    end
    q.push_back(cur_exp());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic to_tick();
    int guard;
    guard = 0;
    while (!(m_state == 1 && m_cnt == TD - 1)) begin
      if (guard > 2 * TD) begin
        n_vec++; n_bad++;
        $display("FAIL tick_wait: no tick within %0d cycles (state %0d)", guard, m_state);
        return;
      end
      guard++;
      idle();
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      to_tick();
      idle();
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic back_to_start();
    step(0, 0, 0, 0, 0, 1, 0);
    if (m_state != 0) begin
      step(0, 0, 0, 0, 0, 0, 1);
      idle();
    end
  endtask

  initial begin
    rst = 1'b1;
    key_up = 0; key_down = 0; key_left = 0; key_right = 0;
    restart = 0; add_cube = 0; pix_x = '0; pix_y = '0;
    model_reset();

    repeat (3) step(0, 0, 0, 0, 0, 0, 1);
    repeat (2) idle();
    settle();
    cp("reset.head_x", int'(head_x), 10);
    cp("reset.state", int'(game_state), 0);

    // Start moving right, three moves
    step(0, 0, 0, 1, 0, 0, 0);
    ticks(3);
    settle();
    cp("run3.head_x", int'(head_x), 13);
    cp("run3.head_y", int'(head_y), 15);
    cp("run3.len", int'(body_len), 3);
    cp("run3.state", int'(game_state), 1);

    // Reverse ignored, then turn up
    step(0, 0, 1, 0, 0, 0, 0);
    ticks(1);
    settle();
    cp("rev_ignored.head_x", int'(head_x), 14);
    step(1, 0, 0, 0, 0, 0, 0);
    ticks(1);
    settle();
    cp("turn_up.head_y", int'(head_y), 14);

    // Growth mid-interval, then growth in the tick cycle
    step(0, 0, 0, 0, 1, 0, 0);
    ticks(1);
    settle();
    cp("grow_mid.len", int'(body_len), 4);
    to_tick();
    step(0, 0, 0, 0, 1, 0, 0);
    settle();
    cp("grow_tick.len", int'(body_len), 5);

    // Run right into the wall
    step(0, 0, 0, 1, 0, 0, 0);
    while (m_state == 1 && bx[0] < 38) ticks(1);
    ticks(1);
    settle();
`ifndef WRAP_EN
    cp("wall.hit_wall", int'(hit_wall), 1);
    cp("wall.state", int'(game_state), 2);
    cp("wall.head_x", int'(head_x), 38);
`endif

    // Self collision from a length-5 snake
    back_to_start();
    settle();
    cp("restart.head_x", int'(head_x), 10);
    cp("restart.len", int'(body_len), 3);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    ticks(1);
    step(0, 0, 0, 0, 1, 0, 0);
    ticks(1);
    step(1, 0, 0, 0, 0, 0, 0);
    ticks(1);
    step(0, 0, 1, 0, 0, 0, 0);
    ticks(1);
    step(0, 1, 0, 0, 0, 0, 0);
    ticks(1);
    settle();
    cp("self.hit_body", int'(hit_body), 1);
    cp("self.state", int'(game_state), 2);
    step(0, 0, 0, 0, 0, 1, 0);
    settle();
    cp("self_restart.state", int'(game_state), 0);
    cp("self_restart.head_y", int'(head_y), 15);
    cp("self_restart.len", int'(body_len), 3);

    // Random play
    for (int n = 0; n < 2000; n++) begin
      bit [3:0] kv;
      bit a, rs;
      kv = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'd0;
      a  = ($urandom_range(15, 0) == 0);
      rs = (m_state == 2) ? ($urandom_range(3, 0) == 0) : ($urandom_range(31, 0) == 0);
      step(kv[3], kv[2], kv[1], kv[0], a, rs, 0);
    end

    // Async reset mid-run between ticks
    back_to_start();
    step(0, 0, 0, 1, 0, 0, 0);
    ticks(2);
    repeat (3) idle();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle();

    // Length saturates at MAX_LEN
    step(0, 0, 0, 1, 0, 0, 0);
    repeat (20) begin
      to_tick();
      step(0, 0, 0, 0, 1, 0, 0);
    end
    settle();
    cp("sat.len", int'(body_len), 16);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain: %0d expected vectors left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
